// File: rtl/lib_rr_arbiter_lock.sv
// Round-robin arbiter with a registered one-hot grant and multi-cycle grant locking.
// A one-hot rotating pointer picks the search start; a held lock is force-released
// after MAX_HOLD enabled cycles so that a single requester cannot starve the others.
module lib_rr_arbiter_lock #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic [0:N-1]     i_request,
  input  logic [0:N-1]     i_hold,
  output logic [0:N-1]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_valid,
  output logic             o_timeout
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic             state_q, state_d;
  logic [0:N-1]     grant_q, grant_d;
  logic [0:N-1]     ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             timeout_q, timeout_d;

  // First set bit of req, starting at the pointer position and wrapping N-1 -> 0.
  function automatic logic [0:N-1] arb(input logic [0:N-1] req, input logic [0:N-1] ptr);
    logic [0:N-1] g;
    logic         found;
    int           p;
    int           j;
    g     = '0;
    found = 1'b0;
    p     = 0;
    for (int i = 0; i < N; i++) if (ptr[i]) p = i;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (!found && req[j]) begin
        g[j]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Binary index of a one-hot (or zero) vector.
  function automatic int idx_of(input logic [0:N-1] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Next-state: hold or extend the lock, else (re-)arbitrate with the released owner masked.
  always_comb begin
    logic         keep;
    logic         own_req;
    logic [0:N-1] mask;
    logic [0:N-1] g;
    int           gi;
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    mask      = '1;
    g         = '0;
    gi        = 0;
    own_req   = i_request[owner_q] & i_hold[owner_q];
    keep      = (state_q == ST_LOCKED) && own_req && ((MAX_HOLD == 0) || (cnt_q < MAX_C));
    if (i_en) begin
      if (keep) begin
        if ((MAX_HOLD != 0) && (cnt_q < MAX_C)) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        if (state_q == ST_LOCKED) begin
          mask[owner_q] = 1'b0;
          // Owner still wants the lock, so the only reason to drop it is the hold limit.
          timeout_d     = own_req;
        end
        g       = arb(i_request & mask, ptr_q);
        grant_d = g;
        state_d = ST_IDLE;
        if (|g) begin
          gi                 = idx_of(g);
          ptr_d              = '0;
          ptr_d[(gi + 1) % N] = 1'b1;
          if (i_hold[gi]) begin
            state_d = ST_LOCKED;
            owner_d = IDX_W'(gi);
            cnt_d   = CNT_W'(1);
          end
        end
      end
    end
  end

  // State registers; reset drops any lock and points priority back at requester 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= {1'b1, {(N-1){1'b0}}};
      cnt_q     <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs derived from the grant register so index and valid always agree with it.
  always_comb begin
    o_grant     = grant_q;
    o_valid     = |grant_q;
    o_grant_idx = IDX_W'(idx_of(grant_q));
    o_timeout   = timeout_q;
  end

endmodule
